n_way_link_arbiter: RTL

// - Merges N upstream links onto one downstream link. It is the many-to-one counterpart
//   of the 1-to-N link switch in the interconnect.
// - Round-robin arbitration feeds a 2-entry registered output buffer. Packets (tag + data)

---
 rtl/n_way_link_arbiter_if.sv | 21 ++
 rtl/n_way_link_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/n_way_link_arbiter_if.sv
// Packet type and the req/ack link interface shared by the arbiter and its neighbours.
package link_pkg;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } packet_t;
endpackage

interface link_if;
  import link_pkg::*;

  logic    req;
  logic    ack;
  packet_t packet;

  modport sender   (output req, output packet, input ack);
  modport receiver (input req, input packet, output ack);
endinterface

// File: rtl/n_way_link_arbiter.sv
// N-to-1 link arbiter: round-robin grant into a 2-entry output FIFO.
// Define TIA_LINK_ARBITER_FIXED_PRIORITY_EN for lowest-index-first arbitration.
module n_way_link_arbiter
  import link_pkg::*;
#(
  parameter int N = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic [N-1:0]    input_mask,
  link_if.receiver        input_links [N-1:0],
  link_if.sender          output_link
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     req_vec;
  logic [N-1:0]     ack_vec;
  logic [N-1:0]     elig;
  packet_t          pkt_vec [N];

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_valid;

  packet_t          mem [2];
  logic             rd_sel;
  logic             wr_sel;
  logic [1:0]       count;
  logic [1:0]       count_next;
  logic             space;
  logic             push;
  logic             pop;
  logic             out_valid;

  for (genvar i = 0; i < N; i++) begin : g_links
    assign req_vec[i]         = input_links[i].req;
    assign pkt_vec[i]         = input_links[i].packet;
    assign input_links[i].ack = ack_vec[i];
  end

  // Space is purely a function of the registered count, never of the downstream ack.
  assign space = (count < 2'd2);
  assign elig  = (!reset && enable && space) ? (input_mask & req_vec) : '0;

  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    logic [PTR_W-1:0] idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 0; k < N; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N);
      if (!grant_valid && elig[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  always_comb begin
    ack_vec = '0;
    if (grant_valid) ack_vec[grant_idx] = 1'b1;
  end

`ifdef TIA_LINK_ARBITER_FIXED_PRIORITY_EN
  assign ptr_next = '0;
`else
  always_comb begin
    ptr_next = ptr;
    if (grant_valid)
      ptr_next = (grant_idx == PTR_W'(N - 1)) ? '0 : grant_idx + 1'b1;
  end
`endif

  assign out_valid = (count != 2'd0);
  assign push      = grant_valid;
  assign pop       = out_valid && output_link.ack;
  // With one entry held and a pop in the same edge, the new entry lands in the slot that becomes head.
  assign wr_sel    = rd_sel ^ count[0];

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr    <= '0;
      count  <= '0;
      rd_sel <= 1'b0;
    end else begin
      ptr    <= ptr_next;
      count  <= count_next;
      if (pop) rd_sel <= ~rd_sel;
    end
  end

  // NOTE: the two storage slots are reset too; they are tiny, and stale packets never linger after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (push) begin
      mem[wr_sel] <= pkt_vec[grant_idx];
    end
  end

  assign output_link.req    = out_valid;
  assign output_link.packet = out_valid ? mem[rd_sel] : '0;

endmodule
